// File: rtl/axi_stream_monitor.sv
// Passive AXI4-stream protocol monitor: per-rule violation detection, sticky flags,
// first-error capture and saturating error/traffic counters for a status register block.
module axi_stream_monitor #(
  parameter int BW              = 4,
  parameter int CNT_W           = 32,
  parameter int CHK_MASTER_HOLD = 1,
  parameter int CHK_SLAVE_HOLD  = 0,
  parameter int CHK_PACKED      = 0,
  parameter int MAX_PKT_BEATS   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              tready,
  input  logic              tvalid,
  input  logic [8*BW-1:0]   tdata,
  input  logic [BW-1:0]     tkeep,
  input  logic              tlast,
  output logic [5:0]        err_flags,
  output logic [5:0]        err_first,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  byte_count,
  output logic [CNT_W-1:0]  cur_pkt_beats
);

  localparam int DW = 8*BW;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic             tvalid_q, tready_q, tlast_q;
  logic [DW-1:0]    tdata_q;
  logic [BW-1:0]    tkeep_q;
  logic [5:0]       flags_q, flags_d, first_q, first_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] errc_q, errc_d, beat_q, beat_d, pkt_q, pkt_d;
  logic [CNT_W-1:0] byte_q, byte_d, cur_q, cur_d;

  logic             stall_d, wait_d, hs;
  logic [5:0]       v;
  logic [BW-1:0]    keep_inc;
  logic [CNT_W-1:0] keep_cnt;

  assign stall_d  = tvalid_q & ~tready_q;
  assign wait_d   = tready_q & ~tvalid_q;
  assign hs       = tvalid & tready;
  assign keep_inc = tkeep + BW'(1);

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < BW; i++) keep_cnt = keep_cnt + CNT_W'(tkeep[i]);
  end

  // A last beat may be partial, but only as a run of ones from bit 0.
  always_comb begin
    v    = '0;
    v[0] = (CHK_MASTER_HOLD != 0) && stall_d && !tvalid;
    v[1] = (CHK_MASTER_HOLD != 0) && stall_d && tvalid &&
           ({tdata, tkeep, tlast} != {tdata_q, tkeep_q, tlast_q});
    v[2] = (CHK_SLAVE_HOLD != 0) && wait_d && !tready;
    v[3] = (CHK_PACKED != 0) && hs &&
           (tlast ? ((tkeep & keep_inc) != '0) : (tkeep != '1));
    v[4] = hs && (tkeep == '0);
    v[5] = (MAX_PKT_BEATS > 0) && hs && (cur_q >= CNT_W'(MAX_PKT_BEATS));
  end

  // clear acts first, then this cycle's events are applied on top of it.
  always_comb begin
    logic [5:0]       flags_b;
    logic [CNT_W-1:0] errc_b, beat_b, pkt_b, byte_b, cur_b;
    flags_b = clear ? '0 : flags_q;
    errc_b  = clear ? '0 : errc_q;
    beat_b  = clear ? '0 : beat_q;
    pkt_b   = clear ? '0 : pkt_q;
    byte_b  = clear ? '0 : byte_q;
    cur_b   = clear ? '0 : cur_q;

    flags_d = flags_b | v;
    pulse_d = |v;
    errc_d  = (|v) ? sat_add(errc_b, CNT_W'(1)) : errc_b;
    beat_d  = hs ? sat_add(beat_b, CNT_W'(1)) : beat_b;
    pkt_d   = (hs && tlast) ? sat_add(pkt_b, CNT_W'(1)) : pkt_b;
    byte_d  = hs ? sat_add(byte_b, keep_cnt) : byte_b;

    if (hs && tlast)  cur_d = '0;
    else if (hs)      cur_d = sat_add(cur_b, CNT_W'(1));
    else              cur_d = cur_b;

    if (clear)                        first_d = v;
    else if (flags_q == '0 && (|v))   first_d = v;
    else                              first_d = first_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      flags_q  <= '0;
      first_q  <= '0;
      pulse_q  <= 1'b0;
      errc_q   <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      byte_q   <= '0;
      cur_q    <= '0;
    end else begin
      tvalid_q <= tvalid;
      tready_q <= tready;
      tlast_q  <= tlast;
      tdata_q  <= tdata;
      tkeep_q  <= tkeep;
      flags_q  <= flags_d;
      first_q  <= first_d;
      pulse_q  <= pulse_d;
      errc_q   <= errc_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      byte_q   <= byte_d;
      cur_q    <= cur_d;
    end
  end

  assign err_flags     = flags_q;
  assign err_first     = first_q;
  assign err_pulse     = pulse_q;
  assign err_count     = errc_q;
  assign beat_count    = beat_q;
  assign pkt_count     = pkt_q;
  assign byte_count    = byte_q;
  assign cur_pkt_beats = cur_q;

endmodule

// File: tb/tb_axi_stream_monitor.sv
// Directed bench: u_a has all hold/packing rules on (CNT_W=8); u_b has a 4-beat
// packet limit and 4-bit counters so saturation is reachable. Both see the same stream.
module tb_axi_stream_monitor;

  logic        clk = 1'b0;
  logic        rst, clear, tready, tvalid, tlast;
  logic [31:0] tdata;
  logic [3:0]  tkeep;

  logic [5:0]  a_flags, a_first, b_flags, b_first;
  logic        a_pulse, b_pulse;
  logic [7:0]  a_errc, a_beat, a_pkt, a_byte, a_cur;
  logic [3:0]  b_errc, b_beat, b_pkt, b_byte, b_cur;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axi_stream_monitor #(.BW(4), .CNT_W(8), .CHK_MASTER_HOLD(1), .CHK_SLAVE_HOLD(1),
                       .CHK_PACKED(1), .MAX_PKT_BEATS(0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .tready(tready), .tvalid(tvalid),
    .tdata(tdata), .tkeep(tkeep), .tlast(tlast),
    .err_flags(a_flags), .err_first(a_first), .err_pulse(a_pulse), .err_count(a_errc),
    .beat_count(a_beat), .pkt_count(a_pkt), .byte_count(a_byte), .cur_pkt_beats(a_cur));

  axi_stream_monitor #(.BW(4), .CNT_W(4), .CHK_MASTER_HOLD(1), .CHK_SLAVE_HOLD(0),
                       .CHK_PACKED(0), .MAX_PKT_BEATS(4)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .tready(tready), .tvalid(tvalid),
    .tdata(tdata), .tkeep(tkeep), .tlast(tlast),
    .err_flags(b_flags), .err_first(b_first), .err_pulse(b_pulse), .err_count(b_errc),
    .beat_count(b_beat), .pkt_count(b_pkt), .byte_count(b_byte), .cur_pkt_beats(b_cur));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stream inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic r, input logic [31:0] d,
                      input logic [3:0] k, input logic l);
    tvalid = v; tready = r; tdata = d; tkeep = k; tlast = l;
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    tvalid = 1'b0; tready = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset flags",  a_flags, 6'h0);
    chk("reset first",  a_first, 6'h0);
    chk("reset pulse",  a_pulse, 1'b0);
    chk("reset beats",  a_beat,  8'd0);
    chk("reset cur",    b_cur,   4'd0);

    // Clean traffic: 3 packets x 5 beats, last beat tkeep=3.
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 5; b++)
        step(1'b1, 1'b1, 32'(p*5 + b), (b == 4) ? 4'h3 : 4'hF, b == 4);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("clean beats", a_beat,  8'd15);
    chk("clean pkts",  a_pkt,   8'd3);
    chk("clean bytes", a_byte,  8'd54);
    chk("clean flags", a_flags, 6'h0);
    chk("clean cur",   a_cur,   8'd0);

    // Data changes while stalled.
    do_clear();
    chk("clear beats", a_beat, 8'd0);
    step(1'b1, 1'b0, 32'hA5, 4'hF, 1'b0);
    chk("stall pulse0", a_pulse, 1'b0);
    step(1'b1, 1'b0, 32'h5A, 4'hF, 1'b0);
    chk("v1 flags", a_flags, 6'b000010);
    chk("v1 first", a_first, 6'b000010);
    chk("v1 pulse", a_pulse, 1'b1);
    chk("v1 count", a_errc,  8'd1);
    step(1'b1, 1'b1, 32'h5A, 4'hF, 1'b0);
    chk("v1 pulse drop", a_pulse, 1'b0);
    chk("v1 count hold", a_errc,  8'd1);
    chk("v1 beat",       a_beat,  8'd1);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // tvalid withdrawn while stalled, then tready withdrawn while idle.
    do_clear();
    step(1'b1, 1'b0, 32'h11, 4'hF, 1'b0);
    step(1'b0, 1'b0, 32'h11, 4'hF, 1'b0);
    step(1'b0, 1'b1, 32'h0,  4'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0,  4'h0, 1'b0);
    chk("v0v2 flags", a_flags, 6'b000101);
    chk("v0v2 first", a_first, 6'b000001);
    chk("v0v2 count", a_errc,  8'd2);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // Packing rule: partial non-last, non-contiguous last, empty beat.
    do_clear();
    step(1'b1, 1'b1, 32'h1, 4'h7, 1'b0);
    chk("v3 nonlast", a_flags, 6'b001000);
    step(1'b1, 1'b1, 32'h2, 4'h5, 1'b1);
    chk("v3 last cnt", a_errc, 8'd2);
    step(1'b1, 1'b1, 32'h3, 4'h0, 1'b0);
    chk("pack flags", a_flags, 6'b011000);
    chk("pack first", a_first, 6'b001000);
    chk("pack count", a_errc,  8'd3);
    chk("pack bytes", a_byte,  8'd5);
    chk("pack cur",   a_cur,   8'd1);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // Packet length limit of 4 beats on u_b.
    do_clear();
    for (int b = 0; b < 6; b++) begin
      step(1'b1, 1'b1, 32'(b), 4'hF, b == 5);
      if (b == 3) begin
        chk("len4 errc", b_errc, 4'd0);
        chk("len4 cur",  b_cur,  4'd4);
      end
    end
    chk("len6 errc",  b_errc,  4'd2);
    chk("len6 flags", b_flags, 6'b100000);
    chk("len6 first", b_first, 6'b100000);
    for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 32'(b), 4'hF, b == 3);
    chk("len next errc", b_errc, 4'd2);
    chk("len next pkts", b_pkt,  4'd2);
    chk("len a errc",    a_errc, 8'd0);
    chk("len a bytes",   a_byte, 8'd40);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // clear coinciding with a v1 violation and a handshake.
    step(1'b1, 1'b0, 32'hC3, 4'hF, 1'b0);
    clear = 1'b1;
    step(1'b1, 1'b1, 32'h3C, 4'hF, 1'b0);
    clear = 1'b0;
    chk("clr+v flags", a_flags, 6'b000010);
    chk("clr+v first", a_first, 6'b000010);
    chk("clr+v errc",  a_errc,  8'd1);
    chk("clr+v pulse", a_pulse, 1'b1);
    chk("clr+v beats", a_beat,  8'd1);
    chk("clr+v bytes", a_byte,  8'd4);
    chk("clr+v cur",   a_cur,   8'd1);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // Saturation of 4-bit counters on u_b with one long open packet.
    do_clear();
    for (int b = 0; b < 20; b++) step(1'b1, 1'b1, 32'(b), 4'hF, 1'b0);
    chk("sat beats", b_beat, 4'd15);
    chk("sat bytes", b_byte, 4'd15);
    chk("sat errc",  b_errc, 4'd15);
    chk("sat cur",   b_cur,  4'd15);
    chk("sat pkts",  b_pkt,  4'd0);
    chk("sat a beats", a_beat, 8'd20);
    chk("sat a bytes", a_byte, 8'd80);
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);

    // Asynchronous reset mid-packet while stalled.
    step(1'b1, 1'b1, 32'h77, 4'hF, 1'b0);
    step(1'b1, 1'b0, 32'h78, 4'hF, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst a beats", a_beat,  8'd0);
    chk("arst a cur",   a_cur,   8'd0);
    chk("arst b flags", b_flags, 6'h0);
    chk("arst b errc",  b_errc,  4'd0);
    chk("arst b first", b_first, 6'h0);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    chk("post-rst flags", a_flags, 6'h0);
    chk("post-rst pulse", a_pulse, 1'b0);
    chk("post-rst errc",  a_errc,  8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_stream_monitor.md
Name: axi_stream_monitor

Overview:
- Synthesizable, parametrised AXI4-stream protocol monitor that taps a stream without driving it.
- Per-rule enables, sticky error flags, first-error capture, saturating error and traffic counters, and a packet-length limit check.
- Sits beside any AXI-stream link in the FTDI 245-FIFO datapath; outputs go to a debug/status register block, so link health is visible in hardware as well as in simulation.

Parameters:
- BW, 4: data byte-width; tdata is 8*BW bits, tkeep is BW bits.
- CNT_W, 32: width of all counters.
- CHK_MASTER_HOLD, 1: enable rules 0 and 1.
- CHK_SLAVE_HOLD, 0: enable rule 2.
- CHK_PACKED, 0: enable rule 3.
- MAX_PKT_BEATS, 0: packet beat limit; 0 disables rule 5.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clear  in  1  synchronous clear of flags and counters
- tready  in  1  monitored tready
- tvalid  in  1  monitored tvalid
- tdata  in  8*BW  monitored tdata
- tkeep  in  BW  monitored tkeep
- tlast  in  1  monitored tlast
- err_flags  out  6  sticky per-rule violation flags
- err_first  out  6  violation vector of the first violating cycle
- err_pulse  out  1  one-cycle pulse per violating cycle
- err_count  out  CNT_W  number of violating cycles
- beat_count  out  CNT_W  handshake beats
- pkt_count  out  CNT_W  tlast handshakes
- byte_count  out  CNT_W  sum of set tkeep bits over handshakes
- cur_pkt_beats  out  CNT_W  beats so far in the open packet

Behaviour:
- Reset: every output is 0, including all internal delayed copies. rst asserts asynchronously and deasserts synchronously to clk.
- Delayed copies: tvalid_d, tready_d, tdata_d, tkeep_d and tlast_d are registered every cycle.
- Stall: stall_d = tvalid_d & ~tready_d.
- Slave-wait: wait_d = tready_d & ~tvalid_d.
- Handshake: hs = tvalid & tready.
- Combinational violation vector v[5:0]; a disabled rule's bit is forced to 0.
  - v0: stall_d & ~tvalid (tvalid withdrawn).
  - v1: stall_d & tvalid & ({tdata, tkeep, tlast} differs from the delayed copies).
  - v2: wait_d & ~tready (tready withdrawn).
  - v3: hs & ~tlast & tkeep != all-ones; or hs & tlast & tkeep not a contiguous run of ones starting at bit 0.
  - v4: hs & tkeep == 0. Always enabled.
  - v5: MAX_PKT_BEATS>0 & hs & cur_pkt_beats >= MAX_PKT_BEATS.
- Latency: all outputs update on the clk edge after the violating or handshake cycle, i.e. 1 cycle.
- err_flags: err_flags <= err_flags | v. Bits are never cleared except by rst or clear.
- err_first: loaded with v on the first cycle where v != 0 and err_flags == 0. It is then frozen.
- err_pulse: err_pulse <= |v.
- err_count: +1 per cycle with |v.
- beat_count: +1 per hs.
- pkt_count: +1 per hs & tlast.
- byte_count: + popcount(tkeep) per hs.
- Saturation: all counters saturate at 2^CNT_W-1 and never wrap.
- cur_pkt_beats:
  - hs & ~tlast: +1, saturating.
  - hs & tlast: 0.
  - Otherwise: held.
- Packet-length boundary: the beat that makes the packet MAX_PKT_BEATS+1 long sets v5. Every further beat of the same packet also sets v5.
- clear:
  - Zeroes flags, err_first, all counters and cur_pkt_beats.
  - Delayed copies are unaffected.
  - clear and violation in the same cycle: result is the clear followed by that cycle's v. err_flags=v, err_first=v, err_count=1, err_pulse=1.
  - clear and hs in the same cycle: beat_count=1 and byte_count=popcount(tkeep). cur_pkt_beats is 1, or 0 if tlast.
- Mid-operation reset: all state returns to 0. The first cycle after rst cannot raise v0, v1 or v2 because stall_d=wait_d=0.
- X/Z inputs: no required behaviour. Bench-side assertions handle them.

Test Plan:
- Clean traffic, BW=4: 3 packets of 5 beats, tkeep=4'hF except last beat 4'h3 -> beat_count=15, pkt_count=3, byte_count=54, err_flags=0, cur_pkt_beats=0.
- tvalid=1, tready=0 at cycle N; tdata changes at N+1 -> err_flags=6'b000010, err_first=6'b000010, err_pulse high for exactly 1 cycle, err_count=1.
- tvalid dropped while stalled, then CHK_SLAVE_HOLD=1 with tready dropped while idle -> err_flags=6'b000101, err_first=6'b000001, err_count=2.
- CHK_PACKED=1: non-last beat tkeep=4'h7; last beat tkeep=4'h5; beat with tkeep=0 -> v3, v3, then v3|v4; err_flags=6'b011000.
- MAX_PKT_BEATS=4: packet of 6 beats -> err_count=2 (beats 5 and 6), err_flags bit5=1. The next 4-beat packet adds no errors.
- clear pulsed in the same cycle as a v1 violation and a handshake with tkeep=4'hF -> next cycle err_flags=6'b000010, err_count=1, beat_count=1, byte_count=4. Async rst mid-packet -> all outputs 0 immediately.
